// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - opcode, forwarding and FSM definitions shared by the pipeline controller
package pipeline_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_HALT  = 6'b111111;

    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_SUB   = 6'b100010;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FILL   = 3'd1,
        ST_RUN    = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_HALTED = 3'd4
    } state_t;

    typedef struct packed {
        logic       valid;
        logic [4:0] dest;
        logic       is_load;
    } shadow_t;

    // Newer producer (EX) wins over MEM; loads in EX never forward, they stall instead.
    function automatic logic [1:0] fwd_sel(input logic used, input logic [4:0] src,
                                           input shadow_t ex, input shadow_t mem);
        if (used && (src != 5'd0) && ex.valid && !ex.is_load && (ex.dest == src))
            return FWD_EXMEM;
        if (used && (src != 5'd0) && mem.valid && (mem.dest == src))
            return FWD_MEMWB;
        return FWD_RF;
    endfunction

endpackage

// File: rtl/instr_regdecode.sv
// rtl/instr_regdecode.sv - combinational register-usage decode of one instruction
module instr_regdecode
    import pipeline_pkg::*;
(
    input  logic [31:0] i_instr,
    output logic [4:0]  o_src1,
    output logic        o_src1_used,
    output logic [4:0]  o_src2,
    output logic        o_src2_used,
    output logic [4:0]  o_dest,
    output logic        o_writes,
    output logic        o_is_load,
    output logic        o_is_halt
);

    logic [5:0] w_op;
    logic [5:0] w_funct;
    logic       w_unused_shamt;

    assign w_op           = i_instr[31:26];
    assign w_funct        = i_instr[5:0];
    assign w_unused_shamt = ^i_instr[10:6];

    always_comb begin
        o_src1      = i_instr[25:21];
        o_src2      = i_instr[20:16];
        o_src1_used = 1'b0;
        o_src2_used = 1'b0;
        o_dest      = 5'd0;
        o_writes    = 1'b0;
        o_is_load   = 1'b0;
        o_is_halt   = 1'b0;
        case (w_op)
            OP_RTYPE: begin
                // Only add and sub are real R-type ops; other functs behave as NOP.
                if ((w_funct == FN_ADD) || (w_funct == FN_SUB)) begin
                    o_src1_used = 1'b1;
                    o_src2_used = 1'b1;
                    o_dest      = i_instr[15:11];
                    o_writes    = 1'b1;
                end
            end
            OP_ADDI: begin
                o_src1_used = 1'b1;
                o_dest      = i_instr[20:16];
                o_writes    = 1'b1;
            end
            OP_LW: begin
                o_src1_used = 1'b1;
                o_dest      = i_instr[20:16];
                o_writes    = 1'b1;
                o_is_load   = 1'b1;
            end
            OP_SW, OP_BEQ: begin
                o_src1_used = 1'b1;
                o_src2_used = 1'b1;
            end
            OP_J: begin
                o_writes = 1'b0;
            end
            OP_HALT: begin
                o_is_halt = 1'b1;
            end
            default: begin
                o_writes = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - hazard, forwarding and start/halt sequencing for the five-stage pipeline
module pipeline_ctrl
    import pipeline_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [31:0]      id_instr,
    input  logic             ex_redirect,
    output logic             pc_en,
    output logic             pc_sel,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             running,
    output logic             done,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t           r_state;
    logic [1:0]       r_drain_cnt;
    shadow_t          r_ex;
    shadow_t          r_mem;
    shadow_t          r_wb;
    logic [1:0]       r_fwd_a;
    logic [1:0]       r_fwd_b;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    logic [4:0] w_src1;
    logic       w_src1_used;
    logic [4:0] w_src2;
    logic       w_src2_used;
    logic [4:0] w_dest;
    logic       w_writes;
    logic       w_is_load;
    logic       w_is_halt;
    logic       w_ex_load_live;
    logic       w_load_use;
    logic       w_redirect;
    logic       w_stall_evt;
    logic       w_go_drain;
    logic       w_unused_wb;

    instr_regdecode u_decode (
        .i_instr     (id_instr),
        .o_src1      (w_src1),
        .o_src1_used (w_src1_used),
        .o_src2      (w_src2),
        .o_src2_used (w_src2_used),
        .o_dest      (w_dest),
        .o_writes    (w_writes),
        .o_is_load   (w_is_load),
        .o_is_halt   (w_is_halt)
    );

    // The WB slot only completes the retirement picture; the register bank is write-through.
    assign w_unused_wb = ^r_wb;

    assign w_ex_load_live = r_ex.valid && r_ex.is_load && (r_ex.dest != 5'd0);
    assign w_load_use     = w_ex_load_live &&
                            ((w_src1_used && (w_src1 == r_ex.dest)) ||
                             (w_src2_used && (w_src2 == r_ex.dest)));
    assign w_redirect     = (r_state == ST_RUN) && ex_redirect;

    always_comb begin
        pc_en       = 1'b0;
        pc_sel      = 1'b0;
        ifid_en     = 1'b0;
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
        w_stall_evt = 1'b0;
        w_go_drain  = 1'b0;
        case (r_state)
            ST_FILL: begin
                pc_en = 1'b1;
            end
            ST_RUN: begin
                if (w_redirect) begin
                    pc_en   = 1'b1;
                    pc_sel  = 1'b1;
                    ifid_en = 1'b1;
                end else if (w_load_use) begin
                    ifid_flush  = 1'b0;
                    w_stall_evt = 1'b1;
                end else if (w_is_halt) begin
                    // Freeze fetch and bubble the HALT; the older instructions drain.
                    ifid_flush = 1'b0;
                    w_go_drain = 1'b1;
                end else begin
                    pc_en       = 1'b1;
                    ifid_en     = 1'b1;
                    ifid_flush  = 1'b0;
                    idex_bubble = 1'b0;
                end
            end
            default: begin
                pc_en = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_drain_cnt <= 2'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start)
                        r_state <= ST_FILL;
                end
                ST_FILL: begin
                    r_state <= ST_RUN;
                end
                ST_RUN: begin
                    if (w_go_drain) begin
                        r_state     <= ST_DRAIN;
                        r_drain_cnt <= 2'd0;
                    end
                end
                ST_DRAIN: begin
                    if (r_drain_cnt == 2'd2)
                        r_state <= ST_HALTED;
                    else
                        r_drain_cnt <= r_drain_cnt + 2'd1;
                end
                default: begin
                    r_state <= ST_HALTED;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ex    <= '0;
            r_mem   <= '0;
            r_wb    <= '0;
            r_fwd_a <= FWD_RF;
            r_fwd_b <= FWD_RF;
        end else begin
            r_mem <= r_ex;
            r_wb  <= r_mem;
            if (idex_bubble) begin
                r_ex    <= '0;
                r_fwd_a <= FWD_RF;
                r_fwd_b <= FWD_RF;
            end else begin
                r_ex    <= '{valid: w_writes, dest: w_dest, is_load: w_is_load};
                r_fwd_a <= fwd_sel(w_src1_used, w_src1, r_ex, r_mem);
                r_fwd_b <= fwd_sel(w_src2_used, w_src2, r_ex, r_mem);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall_evt && (r_stall_cnt != CNT_MAX))
                r_stall_cnt <= r_stall_cnt + CNT_ONE;
            if (w_redirect && (r_flush_cnt != CNT_MAX))
                r_flush_cnt <= r_flush_cnt + CNT_ONE;
        end
    end

    assign fwd_a     = r_fwd_a;
    assign fwd_b     = r_fwd_b;
    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;
    assign running   = (r_state == ST_RUN);
    assign done      = (r_state == ST_HALTED);

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb/tb_pipeline_ctrl.sv - directed plus random checks of pipeline_ctrl against an instruction-flow model
module tb_pipeline_ctrl;

    localparam logic [5:0] T_ADDI = 6'h08;
    localparam logic [5:0] T_LW   = 6'h23;
    localparam logic [5:0] T_SW   = 6'h2b;
    localparam logic [5:0] T_BEQ  = 6'h04;
    localparam logic [5:0] T_J    = 6'h02;
    localparam logic [5:0] T_HALT = 6'h3f;
    localparam logic [5:0] T_ADD  = 6'h20;
    localparam logic [5:0] T_SUB  = 6'h22;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] id_instr;
    logic        ex_redirect;
    logic        pc_en, pc_sel, ifid_en, ifid_flush, idex_bubble;
    logic [1:0]  fwd_a, fwd_b;
    logic        running, done;
    logic [15:0] stall_cnt, flush_cnt;

    int total = 0;
    int bad   = 0;

    logic [31:0] prog[$];
    int          phase;
    int          drain_left;
    logic [31:0] ex_i, mem_i;
    logic [1:0]  e_fa, e_fb;
    int          e_stall, e_flush;
    bit          st;

    pipeline_ctrl #(.CNT_W(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .id_instr    (id_instr),
        .ex_redirect (ex_redirect),
        .pc_en       (pc_en),
        .pc_sel      (pc_sel),
        .ifid_en     (ifid_en),
        .ifid_flush  (ifid_flush),
        .idex_bubble (idex_bubble),
        .fwd_a       (fwd_a),
        .fwd_b       (fwd_b),
        .running     (running),
        .done        (done),
        .stall_cnt   (stall_cnt),
        .flush_cnt   (flush_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] r_op(logic [5:0] fn, int rd, int rs, int rt);
        return {6'd0, rs[4:0], rt[4:0], rd[4:0], 5'd0, fn};
    endfunction

    function automatic logic [31:0] i_op(logic [5:0] op, int rt, int rs, int imm);
        return {op, rs[4:0], rt[4:0], imm[15:0]};
    endfunction

    function automatic bit is_alu_r(logic [31:0] i);
        return (i[31:26] == 6'd0) && ((i[5:0] == T_ADD) || (i[5:0] == T_SUB));
    endfunction

    // Destination register written by an instruction, -1 if none.
    function automatic int dst_of(logic [31:0] i);
        if (is_alu_r(i)) return int'(i[15:11]);
        if ((i[31:26] == T_ADDI) || (i[31:26] == T_LW)) return int'(i[20:16]);
        return -1;
    endfunction

    // Source register k (0 = first, 1 = second) read by an instruction, -1 if none.
    function automatic int src_of(logic [31:0] i, int k);
        if (is_alu_r(i) || (i[31:26] == T_SW) || (i[31:26] == T_BEQ))
            return (k == 0) ? int'(i[25:21]) : int'(i[20:16]);
        if ((i[31:26] == T_ADDI) || (i[31:26] == T_LW))
            return (k == 0) ? int'(i[25:21]) : -1;
        return -1;
    endfunction

    function automatic bit is_ld(logic [31:0] i);
        return i[31:26] == T_LW;
    endfunction

    function automatic logic [1:0] fsel(int s, logic [31:0] ex, logic [31:0] mem);
        if (s > 0 && s == dst_of(ex) && !is_ld(ex)) return 2'b01;
        if (s > 0 && s == dst_of(mem)) return 2'b10;
        return 2'b00;
    endfunction

    function automatic logic [31:0] rnd_instr();
        int k, a, b, c;
        k = $urandom_range(0, 7);
        a = $urandom_range(0, 3);
        b = $urandom_range(0, 3);
        c = $urandom_range(0, 3);
        case (k)
            0: return r_op(T_ADD, a, b, c);
            1: return r_op(T_SUB, a, b, c);
            2: return i_op(T_ADDI, a, b, 7);
            3: return i_op(T_LW, a, b, 4);
            4: return i_op(T_SW, a, b, 8);
            5: return i_op(T_BEQ, a, b, 2);
            6: return {T_J, 26'd5};
            default: return 32'd0;
        endcase
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic reset_model();
        phase = 0; drain_left = 0;
        ex_i = 32'd0; mem_i = 32'd0;
        e_fa = 2'b00; e_fb = 2'b00;
        e_stall = 0; e_flush = 0;
        prog.delete();
    endtask

    // One clock of stimulus: drive ID/redirect, check against the model, advance the model.
    task automatic cycle(input bit redir);
        logic [31:0] ins;
        int          s0, s1, nphase, ndrain, nstall, nflush;
        bit          hz, pop, chk_en, chk_fl;
        logic        e_pc, e_sel, e_ifen, e_fl, e_bub;
        ins = (prog.size() > 0) ? prog[0] : 32'd0;
        id_instr = ins; ex_redirect = redir; start = st;
        #1;
        chk("running", running, phase == 2);
        chk("done", done, phase == 4);
        chk("fwd_a", fwd_a, e_fa);
        chk("fwd_b", fwd_b, e_fb);
        chk("stall_cnt", stall_cnt, e_stall);
        chk("flush_cnt", flush_cnt, e_flush);
        e_pc = 0; e_sel = 0; e_ifen = 0; e_fl = 1; e_bub = 1;
        chk_en = 1; chk_fl = 1; pop = 0;
        nphase = phase; ndrain = drain_left; nstall = e_stall; nflush = e_flush;
        s0 = src_of(ins, 0); s1 = src_of(ins, 1);
        hz = is_ld(ex_i) && dst_of(ex_i) > 0 &&
             (s0 == dst_of(ex_i) || s1 == dst_of(ex_i));
        case (phase)
            0: if (st) nphase = 1;
            1: begin e_pc = 1; nphase = 2; end
            2: begin
                if (redir) begin
                    e_pc = 1; e_sel = 1; chk_en = 0; pop = 1;
                    if (nflush < 65535) nflush++;
                end else if (hz) begin
                    e_fl = 0;
                    if (nstall < 65535) nstall++;
                end else if (ins[31:26] == T_HALT) begin
                    chk_en = 0; chk_fl = 0; pop = 1; nphase = 3; ndrain = 3;
                end else begin
                    e_pc = 1; e_ifen = 1; e_fl = 0; e_bub = 0; pop = 1;
                end
            end
            3: begin
                chk_en = 0; ndrain = drain_left - 1;
                if (ndrain == 0) nphase = 4;
            end
            default: chk_en = 0;
        endcase
        chk("pc_en", pc_en, e_pc);
        chk("pc_sel", pc_sel, e_sel);
        chk("idex_bubble", idex_bubble, e_bub);
        if (chk_en) chk("ifid_en", ifid_en, e_ifen);
        if (chk_fl) chk("ifid_flush", ifid_flush, e_fl);
        @(posedge clk);
        #1;
        e_fa = e_bub ? 2'b00 : fsel(s0, ex_i, mem_i);
        e_fb = e_bub ? 2'b00 : fsel(s1, ex_i, mem_i);
        mem_i = ex_i;
        ex_i = e_bub ? 32'd0 : ins;
        phase = nphase; drain_left = ndrain; e_stall = nstall; e_flush = nflush;
        if (pop && prog.size() > 0) void'(prog.pop_front());
    endtask

    initial begin
        int sb, fb;
        rst = 1'b0; start = 1'b0; id_instr = 32'd0; ex_redirect = 1'b0; st = 0;
        reset_model();
        @(posedge clk);
        #1;
        cycle(0);
        cycle(1);
        rst = 1'b1;
        cycle(0);
        st = 1;
        cycle(0);
        st = 0;
        cycle(0);
        chk("start_running", running, 1'b1);

        prog.push_back(r_op(T_ADD, 3, 1, 2));
        prog.push_back(r_op(T_SUB, 4, 3, 1));
        cycle(0); cycle(0);
        chk("fwd_exmem", fwd_a, 2'b01);
        prog.push_back(r_op(T_ADD, 3, 1, 2));
        prog.push_back(i_op(T_ADDI, 7, 1, 4));
        prog.push_back(r_op(T_SUB, 4, 3, 1));
        cycle(0); cycle(0); cycle(0);
        chk("fwd_memwb", fwd_a, 2'b10);

        sb = e_stall;
        prog.push_back(i_op(T_LW, 5, 1, 0));
        prog.push_back(r_op(T_ADD, 6, 5, 2));
        cycle(0); cycle(0); cycle(0);
        chk("lu_fwd", fwd_a, 2'b10);
        chk("lu_stall", stall_cnt, sb + 1);

        sb = e_stall; fb = e_flush;
        prog.push_back(i_op(T_LW, 5, 1, 0));
        prog.push_back(r_op(T_ADD, 6, 5, 2));
        cycle(0); cycle(1);
        chk("redir_flush", flush_cnt, fb + 1);
        chk("redir_stall", stall_cnt, sb);

        sb = e_stall;
        prog.push_back(i_op(T_ADDI, 0, 0, 5));
        prog.push_back(r_op(T_ADD, 1, 0, 0));
        cycle(0); cycle(0); cycle(0);
        chk("zero_fwd_a", fwd_a, 2'b00);
        chk("zero_fwd_b", fwd_b, 2'b00);
        chk("zero_stall", stall_cnt, sb);

        for (int n = 0; n < 400; n++) begin
            if (prog.size() == 0) prog.push_back(rnd_instr());
            cycle($urandom_range(0, 7) == 0);
        end

        prog.delete();
        prog.push_back({T_HALT, 26'd0});
        cycle(1);
        chk("halt_redir_run", running, 1'b1);
        prog.push_back({T_HALT, 26'd0});
        cycle(0);
        cycle(0); cycle(0);
        chk("halt_not_yet", done, 1'b0);
        cycle(0);
        chk("halt_done", done, 1'b1);
        cycle(0); cycle(0);

        rst = 1'b0;
        #1;
        reset_model();
        cycle(0);
        rst = 1'b1;
        st = 1; cycle(0); st = 0; cycle(0);
        prog.push_back(r_op(T_ADD, 2, 1, 1));
        prog.push_back({T_HALT, 26'd0});
        cycle(0); cycle(0); cycle(0);
        chk("drain_state", pc_en, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_pc_en", pc_en, 1'b0);
        chk("arst_flush", ifid_flush, 1'b1);
        chk("arst_bubble", idex_bubble, 1'b1);
        chk("arst_ifid_en", ifid_en, 1'b0);
        chk("arst_running", running, 1'b0);
        chk("arst_done", done, 1'b0);
        chk("arst_stall", stall_cnt, 16'd0);
        chk("arst_flushcnt", flush_cnt, 16'd0);
        chk("arst_fwd", {fwd_a, fwd_b}, 4'd0);
        @(posedge clk);
        #1;
        reset_model();
        cycle(0);
        rst = 1'b1;
        cycle(0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
